// File: rtl/mem_addr_sel_reg.sv
// Registered memory-address source selector with alignment/selector checking.
// A violation parks the bus on the exception vector until the control unit acknowledges it.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no accepted address yet; addr_valid=0
// ST_VALID | addr_out holds an accepted address (or the vector after clr_fault)
// ST_FAULT | violation latched; addr_out forced to EXC_ADDR until clr_fault
module mem_addr_sel_reg #(
   parameter int                WIDTH    = 32,
   parameter int                N_SRC    = 6,
   parameter int                SEL_W    = 3,
   parameter logic [WIDTH-1:0]  EXC_ADDR = WIDTH'(32'h000000FD)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N_SRC*WIDTH-1:0] data_in,
   input  logic [SEL_W-1:0]       selector,
   input  logic [1:0]             size,
   input  logic                   load,
   input  logic                   clr_fault,
   output logic [WIDTH-1:0]       addr_out,
   output logic                   addr_valid,
   output logic                   fault,
   output logic                   misalign,
   output logic                   sel_err,
   output logic [WIDTH-1:0]       bad_addr,
   output logic [WIDTH-1:0]       prev_addr
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_VALID = 2'd1,
      ST_FAULT = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [WIDTH-1:0]  r_addr;
   logic [WIDTH-1:0]  r_bad;
   logic [WIDTH-1:0]  r_prev;
   logic              r_misalign;
   logic              r_sel_err;
   logic [WIDTH-1:0]  w_cand;
   logic              w_sel_ok;
   logic              w_mis;

   // Out-of-range selectors leave the candidate at zero; they never reach the address path.
   always_comb begin
      w_cand = '0;
      for (int k = 0; k < N_SRC; k++) begin
         if (selector == SEL_W'(k)) begin
            w_cand = data_in[k*WIDTH +: WIDTH];
         end
      end
   end

   assign w_sel_ok = ({1'b0, selector} < (SEL_W+1)'(N_SRC));

   always_comb begin
      case (size)
         2'b01:   w_mis = w_cand[0];
         2'b10:   w_mis = 1'b0;
         default: w_mis = |w_cand[1:0];
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE, ST_VALID: begin
            if (load) begin
               if (!w_sel_ok || w_mis) begin
                  w_state_nxt = ST_FAULT;
               end else begin
                  w_state_nxt = ST_VALID;
               end
            end
         end
         ST_FAULT: begin
            if (clr_fault) begin
               w_state_nxt = ST_VALID;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_addr     <= '0;
         r_bad      <= '0;
         r_prev     <= '0;
         r_misalign <= 1'b0;
         r_sel_err  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_VALID: begin
               if (load) begin
                  if (!w_sel_ok) begin
                     r_addr     <= EXC_ADDR;
                     r_bad      <= '0;
                     r_sel_err  <= 1'b1;
                     r_misalign <= 1'b0;
                  end else if (w_mis) begin
                     r_addr     <= EXC_ADDR;
                     r_bad      <= w_cand;
                     r_sel_err  <= 1'b0;
                     r_misalign <= 1'b1;
                  end else begin
                     r_prev <= r_addr;
                     r_addr <= w_cand;
                  end
               end
            end
            ST_FAULT: begin
               // Acknowledge keeps bad_addr so the handler can still read the culprit.
               if (clr_fault) begin
                  r_addr     <= EXC_ADDR;
                  r_sel_err  <= 1'b0;
                  r_misalign <= 1'b0;
               end
            end
            default: begin
               r_addr <= r_addr;
            end
         endcase
      end
   end

   always_comb begin
      addr_valid = (r_state == ST_VALID);
      fault      = (r_state == ST_FAULT);
      addr_out   = r_addr;
      misalign   = r_misalign;
      sel_err    = r_sel_err;
      bad_addr   = r_bad;
      prev_addr  = r_prev;
   end

endmodule
